// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RV32I core: opcode/funct fields,
// ALU operation and immediate-format enums, and instruction-memory sizing.
package cpu_pkg;

  localparam int IMEM_DEPTH = 1024;
  localparam int IMEM_AW    = 10;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_t;

  // Sign-extended immediate for each RV32I encoding format.
  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_type_t t);
    case (t)
      IMM_I:   return {{20{inst[31]}}, inst[31:20]};
      IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   return {inst[31:12], 12'h000};
      IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // ALU operation for OP / OP-IMM; SUB only exists in the register form.
  function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic is_reg);
    case (f3)
      F3_ADD_SUB: return (is_reg && (f7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      F3_AND:     return ALU_AND;
      default:    return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/inst_mem.sv
// Instruction ROM with a combinational word read. Contents are loaded from
// outside through the hierarchical array mem at time 0; the core never writes it.
module inst_mem
  import cpu_pkg::*;
(
  input  logic [IMEM_AW-1:0] addr,
  output logic [31:0]        data
);

  logic [31:0] mem [0:IMEM_DEPTH-1];

  assign data = mem[addr];

endmodule

// File: rtl/cpu_top.sv
// Single-cycle RV32I core (integer ALU, branches and jumps only). Memory,
// fence and system instructions retire as NOPs. One instruction per clock.
module cpu_top
  import cpu_pkg::*;
(
  input logic clk,
  input logic rst_n
);

  logic [31:0] pc_current_s1;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] inst;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] wb_data;
  logic [31:0] regs [0:31];

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] funct3;

  imm_type_t imm_type;
  alu_op_t   alu_op;
  logic      use_imm;
  logic      use_pc;
  logic      reg_write;
  logic      wb_pc4;
  logic      is_branch;
  logic      is_jal;
  logic      is_jalr;
  logic      take_branch;

  // Fetch ignores PC[1:0]; the 10-bit word index wraps at 4 KiB.
  inst_mem u_inst_mem_s1 (
    .addr (pc_current_s1[11:2]),
    .data (inst)
  );

  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign funct3   = inst[14:12];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign pc_plus4 = pc_current_s1 + 32'd4;
  assign imm      = gen_imm(inst, imm_type);

  // Reads return the value before this cycle's write, so rs1=rs2=rd is safe.
  assign rs1_val = (rs1 == 5'd0) ? 32'h0000_0000 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0000_0000 : regs[rs2];

  assign op_a    = use_pc  ? pc_current_s1 : rs1_val;
  assign op_b    = use_imm ? imm : rs2_val;
  assign wb_data = wb_pc4  ? pc_plus4 : alu_res;

  // Decode: select immediate format, ALU op, operand sources and writeback.
  always_comb begin
    imm_type  = IMM_NONE;
    alu_op    = ALU_ADD;
    use_imm   = 1'b0;
    use_pc    = 1'b0;
    reg_write = 1'b0;
    wb_pc4    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_type  = IMM_U;
        alu_op    = ALU_PASS_B;
        use_imm   = 1'b1;
        reg_write = 1'b1;
      end
      OP_AUIPC: begin
        imm_type  = IMM_U;
        use_imm   = 1'b1;
        use_pc    = 1'b1;
        reg_write = 1'b1;
      end
      OP_JAL: begin
        imm_type  = IMM_J;
        is_jal    = 1'b1;
        reg_write = 1'b1;
        wb_pc4    = 1'b1;
      end
      OP_JALR: begin
        imm_type  = IMM_I;
        use_imm   = 1'b1;
        is_jalr   = 1'b1;
        reg_write = 1'b1;
        wb_pc4    = 1'b1;
      end
      OP_BRANCH: begin
        imm_type  = IMM_B;
        is_branch = 1'b1;
      end
      OP_IMM: begin
        imm_type  = IMM_I;
        use_imm   = 1'b1;
        alu_op    = decode_alu(funct3, inst[31:25], 1'b0);
        reg_write = 1'b1;
      end
      OP_REG: begin
        alu_op    = decode_alu(funct3, inst[31:25], 1'b1);
        reg_write = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_MISC_MEM, OP_SYSTEM: begin
        reg_write = 1'b0;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  // ALU: 32-bit modulo arithmetic, shifts use the low five bits of operand B.
  always_comb begin
    alu_res = 32'h0000_0000;
    case (alu_op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLL:    alu_res = op_a << op_b[4:0];
      ALU_SLT:    alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:   alu_res = {31'd0, (op_a < op_b)};
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SRL:    alu_res = op_a >> op_b[4:0];
      ALU_SRA:    alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_PASS_B: alu_res = op_b;
      default:    alu_res = 32'h0000_0000;
    endcase
  end

  // Branch condition; reserved branch funct3 encodings never take.
  always_comb begin
    take_branch = 1'b0;
    case (funct3)
      F3_BEQ:  take_branch = (rs1_val == rs2_val);
      F3_BNE:  take_branch = (rs1_val != rs2_val);
      F3_BLT:  take_branch = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  take_branch = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: take_branch = (rs1_val < rs2_val);
      F3_BGEU: take_branch = (rs1_val >= rs2_val);
      default: take_branch = 1'b0;
    endcase
  end

  // Next-PC selection: jumps, taken branches, otherwise sequential.
  always_comb begin
    pc_next = pc_plus4;
    if (is_jal) begin
      pc_next = pc_current_s1 + imm;
    end else if (is_jalr) begin
      pc_next = alu_res & 32'hFFFF_FFFE;
    end else if (is_branch && take_branch) begin
      pc_next = pc_current_s1 + imm;
    end else begin
      pc_next = pc_plus4;
    end
  end

  // Program counter; reset forces the fetch address back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_current_s1 <= 32'h0000_0000;
    end else begin
      pc_current_s1 <= pc_next;
    end
  end

  // Register file write port; x0 writes are dropped, reset clears all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else if (reg_write && (rd != 5'd0)) begin
      regs[rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: an instruction-level reference model runs alongside
// the core and the compare process checks PC and every register each cycle.
module tb_cpu_top;

  logic clk;
  logic rst_n;

  int n_err    = 0;
  int n_checks = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] m_mem  [0:1023];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;

  cpu_top dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic write_word(input int idx, input logic [31:0] w);
    dut.u_inst_mem_s1.mem[idx] = w;
    m_mem[idx] = w;
  endtask

  task automatic fill_nops();
    for (int k = 0; k < 1024; k++) write_word(k, 32'h0000_0013);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
  endtask

  function automatic logic [31:0] model_alu(input logic [2:0] f3, input logic sub,
                                            input logic sra, input logic [31:0] a,
                                            input logic [31:0] b);
    case (f3)
      3'd0:    return sub ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return sra ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Execute one instruction on the architectural model.
  task automatic model_step();
    logic [31:0] i, a, b, ii, ib, iu, ij, res, npc;
    logic wr, cond;
    i   = m_mem[m_pc[11:2]];
    a   = m_regs[i[19:15]];
    b   = m_regs[i[24:20]];
    ii  = {{20{i[31]}}, i[31:20]};
    ib  = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    iu  = {i[31:12], 12'h000};
    ij  = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    npc = m_pc + 32'd4;
    wr  = 1'b0;
    res = 32'h0;
    case (i[6:0])
      7'h37: begin res = iu; wr = 1'b1; end
      7'h17: begin res = m_pc + iu; wr = 1'b1; end
      7'h6F: begin res = m_pc + 32'd4; wr = 1'b1; npc = m_pc + ij; end
      7'h67: begin res = m_pc + 32'd4; wr = 1'b1; npc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (i[14:12])
          3'd0: cond = (a == b);
          3'd1: cond = (a != b);
          3'd4: cond = ($signed(a) < $signed(b));
          3'd5: cond = ($signed(a) >= $signed(b));
          3'd6: cond = (a < b);
          3'd7: cond = (a >= b);
          default: cond = 1'b0;
        endcase
        if (cond) npc = m_pc + ib;
      end
      7'h13: begin res = model_alu(i[14:12], 1'b0, i[30], a, ii); wr = 1'b1; end
      7'h33: begin res = model_alu(i[14:12], i[30], i[30], a, b); wr = 1'b1; end
      default: wr = 1'b0;
    endcase
    if (wr && i[11:7] != 5'd0) m_regs[i[11:7]] = res;
    m_pc = npc;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [20:0] jo;
    logic [12:0] bo;
    logic [6:0]  f7;
    int kind;
    r    = $urandom;
    rd   = 5'($urandom_range(0, 15));
    rs1  = 5'($urandom_range(0, 15));
    rs2  = 5'($urandom_range(0, 15));
    f3   = r[14:12];
    kind = $urandom_range(0, 19);
    case (kind)
      0: return {r[31:12], rd, 7'h37};
      1: return {r[31:12], rd, 7'h17};
      2: begin
        jo = r[12] ? {r[20:2], 2'b00} : {{9{r[11]}}, r[11:2], 2'b00};
        return {jo[20], jo[10:1], jo[11], jo[19:12], rd, 7'h6F};
      end
      3: return {r[31:20], rs1, 3'b000, rd, 7'h67};
      4, 5: begin
        bo = {{3{r[9]}}, r[9:2], 2'b00};
        if (f3[2:1] == 2'b01) f3[2] = 1'b1;
        return {bo[12], bo[10:5], rs2, rs1, f3, bo[4:1], bo[11], 7'h63};
      end
      6, 7, 8, 9, 10: begin
        if (f3 == 3'd1) return {7'h00, r[24:20], rs1, f3, rd, 7'h13};
        if (f3 == 3'd5) return {(r[30] ? 7'h20 : 7'h00), r[24:20], rs1, f3, rd, 7'h13};
        return {r[31:20], rs1, f3, rd, 7'h13};
      end
      11, 12, 13, 14, 15: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      16: return {r[31:20], rs1, 3'b010, rd, 7'h03};
      17: return {r[31:25], rs2, rs1, 3'b010, r[11:7], 7'h23};
      18: return r[0] ? 32'h0000_000F : 32'h0000_0073;
      default: return {r[31:7], 7'h7F};
    endcase
  endfunction

  // Advance the model on every clock edge the core is out of reset.
  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  // Compare architectural state against the model once per cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc", dut.pc_current_s1, m_pc);
      for (int k = 0; k < 32; k++) check($sformatf("x%0d", k), dut.regs[k], m_regs[k]);
    end
  end

  task automatic assert_reset();
    @(negedge clk);
    #5 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pc", dut.pc_current_s1, 32'h0);
    check("rst_x1", dut.regs[1], 32'h0);
  endtask

  task automatic release_reset();
    #9 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    fill_nops();
    write_word(0, 32'h0050_0093);  // addi x1,x0,5
    write_word(1, 32'hFF90_8113);  // addi x2,x1,-7
    write_word(2, 32'h0020_B1B3);  // sltu x3,x1,x2
    write_word(3, 32'h4031_5233);  // sra  x4,x2,x3
    #5 rst_n = 1'b0;
    model_reset();
    #5;
    check("reset_pc", dut.pc_current_s1, 32'h0);
    check("reset_x2", dut.regs[2], 32'h0);
    #5 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #10;
    check("first_edge_pc", dut.pc_current_s1, 32'h4);
    repeat (3) @(posedge clk);
    #10;
    check("alu_x1", dut.regs[1], 32'h0000_0005);
    check("alu_x2", dut.regs[2], 32'hFFFF_FFFE);
    check("alu_x3", dut.regs[3], 32'h0000_0001);
    check("alu_x4", dut.regs[4], 32'hFFFF_FFFF);

    // Jump and link, then return through x1.
    assert_reset();
    fill_nops();
    write_word(0, 32'h0080_00EF);  // jal  x1,+8
    write_word(2, 32'h0000_8067);  // jalr x0,x1,0
    release_reset();
    @(posedge clk); #1 check("jal_pc", dut.pc_current_s1, 32'h8);
    @(posedge clk); #1 check("jalr_pc", dut.pc_current_s1, 32'h4);
    @(posedge clk); #1 check("after_ret_pc", dut.pc_current_s1, 32'h8);
    check("link_x1", dut.regs[1], 32'h4);

    // x0 writes and instructions that retire as NOPs.
    assert_reset();
    fill_nops();
    write_word(0, 32'h0090_0293);  // addi x5,x0,9
    write_word(1, 32'h0010_0013);  // addi x0,x0,1
    write_word(2, 32'h0010_2023);  // sw   x1,0(x0)
    write_word(3, 32'h0000_2283);  // lw   x5,0(x0)
    write_word(4, 32'h0000_000F);  // fence
    write_word(5, 32'h0000_0073);  // ecall
    write_word(6, 32'hFFFF_FFFF);  // undefined opcode
    release_reset();
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1 check($sformatf("nop_pc%0d", k), dut.pc_current_s1, 32'(4 * k));
    end
    check("nop_x0", dut.regs[0], 32'h0);
    check("nop_x5", dut.regs[5], 32'h9);

    // Random programs; a mid-run reset must restart the same image.
    for (int p = 0; p < 6; p++) begin
      assert_reset();
      for (int k = 0; k < 1024; k++) write_word(k, rand_inst());
      release_reset();
      repeat (250) @(posedge clk);
      assert_reset();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("mem_keep%0d", k), dut.u_inst_mem_s1.mem[k * 37], m_mem[k * 37]);
      end
      release_reset();
      repeat (100) @(posedge clk);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
